// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: command opcodes, status marker and frame states shared across the SPI command link
package spi_cmd_pkg;
  localparam int BUF_LEN = 15;
  localparam int CMD_RW_BIT = 7;
  localparam logic CMD_READ = 1'b1;
  localparam logic CMD_WRITE = 1'b0;
  localparam logic [1:0] STATUS_MARKER = 2'b10;
  typedef enum logic [6:0] {
    UPDATE_MTRS     = 7'h00,
    ENCODER_COUNT   = 7'h11,
    HALL_COUNT      = 7'h12,
    DUTY_CYCLE      = 7'h13,
    VERSION         = 7'h14,
    TOGGLE_MOTOR_EN = 7'h30
  } opcode_t;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 SCK timing and MSB-first byte shift with synchronised MISO capture
module spi_byte_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] next_data,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic                  byte_done,
  output logic [DATA_WIDTH-1:0] rx_byte
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [1:0] miso_sync;
  logic phase_end, fall, last_bit;
  assign phase_end = en && div_cnt == DW'(CLK_DIV - 1);
  assign fall = phase_end && sck;
  assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
  // the next byte is taken at the falling edge that ends the current one, so there is no inter-byte gap
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      miso_sync <= '0;
      sck <= 1'b0;
      mosi <= 1'b0;
      byte_done <= 1'b0;
      rx_byte <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      byte_done <= fall && last_bit;
      if (load) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sck <= 1'b0;
        mosi <= load_data[DATA_WIDTH-1];
        sh <= load_data << 1;
      end else if (en) begin
        div_cnt <= phase_end ? '0 : div_cnt + DW'(1);
        if (phase_end) sck <= !sck;
        if (fall) rx_byte <= {rx_byte[DATA_WIDTH-2:0], miso_sync[1]};
        if (fall) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
          mosi <= last_bit ? next_data[DATA_WIDTH-1] : sh[DATA_WIDTH-1];
          sh <= (last_bit ? next_data : sh) << 1;
        end
      end
    end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 initiator issuing one command frame and capturing the status-prefixed response
module spi_frame_master #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_LEN = 15,
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cmd,
  input  logic [3:0]            tx_len,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic                  frame_err,
  output logic [DATA_WIDTH-1:0] status,
  output logic                  spi_ncs,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  import spi_cmd_pkg::*;
  localparam int CW = 16;
  state_t state, state_d;
  logic [CW-1:0] cnt, lim, xfer_len;
  logic [3:0] n, byte_idx, nxt;
  logic [DATA_WIDTH-1:0] tx_buf [BUF_LEN];
  logic [DATA_WIDTH-1:0] rx_buf [BUF_LEN];
  logic [DATA_WIDTH-1:0] next_data, rx_byte;
  logic accept, last, frame_end, byte_done;
  assign busy = state != IDLE;
  assign rd_data = 32'(rd_addr) < BUF_LEN ? rx_buf[rd_addr] : '0;
  always_comb begin
    accept = state == IDLE && start && 32'(tx_len) < BUF_LEN;
    xfer_len = CW'(2 * CLK_DIV * DATA_WIDTH) * CW'(n);
    lim = state == SETUP ? CW'(CS_SETUP - 1) : state == XFER ? xfer_len - CW'(1) :
          state == HOLD ? CW'(CS_HOLD - 1) : CW'(IDLE_GAP - 1);
    last = cnt == lim;
    state_d = state == IDLE ? (accept ? SETUP : IDLE) : !last ? state :
              state == SETUP ? XFER : state == XFER ? HOLD : state == HOLD ? GAP : IDLE;
    frame_end = state == HOLD && last;
    nxt = byte_idx + 4'd1;
    next_data = nxt < n ? tx_buf[nxt] : '0;
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      byte_idx <= '0;
      spi_ncs <= 1'b1;
      done <= 1'b0;
      len_err <= 1'b0;
      frame_err <= 1'b0;
      status <= '0;
      for (int i = 0; i < BUF_LEN; i++) begin
        tx_buf[i] <= '0;
        rx_buf[i] <= '0;
      end
    end else begin
      state <= state_d;
      cnt <= (state_d != state || state == IDLE) ? '0 : cnt + CW'(1);
      spi_ncs <= state_d == IDLE || state_d == GAP;
      done <= frame_end;
      len_err <= state == IDLE && start && !accept;
      if (accept) begin
        tx_buf[0] <= cmd;
        n <= tx_len + 4'd1;
        byte_idx <= '0;
      end else if (byte_done) byte_idx <= nxt;
      if (wr_en && state == IDLE && wr_addr != '0 && 32'(wr_addr) < BUF_LEN) tx_buf[wr_addr] <= wr_data;
      if (byte_done) rx_buf[byte_idx] <= rx_byte;
      if (frame_end) begin
        status <= rx_buf[0];
        frame_err <= rx_buf[0][DATA_WIDTH-1 -: 2] != STATUS_MARKER;
      end
    end
  spi_byte_shifter #(.DATA_WIDTH(DATA_WIDTH), .CLK_DIV(CLK_DIV)) u_shifter (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .load(accept),
    .load_data(cmd),
    .en(state == XFER),
    .next_data(next_data),
    .miso(spi_miso),
    .sck(spi_sck),
    .mosi(spi_mosi),
    .byte_done(byte_done),
    .rx_byte(rx_byte)
  );
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: random frames against a bit-level slave model and byte-level buffer model
module tb_spi_frame_master;
  logic sysclk = 0, rst_n = 0, start = 0, wr_en = 0;
  logic [7:0] cmd = 0, wr_data = 0;
  logic [3:0] tx_len = 0, wr_addr = 0, rd_addr = 0;
  logic [7:0] rd_data, status;
  logic busy, done, len_err, frame_err, spi_ncs, spi_sck, spi_mosi;
  logic spi_miso = 0;
  int checks = 0, errors = 0;
  int ncs_low = 0, done_cnt = 0, ncs_falls = 0, sck_rises = 0, gap_run = 0, min_gap = 1 << 30;
  int bit_o = 0, bit_i = 0;
  logic p_ncs = 1, p_sck = 0;
  logic [7:0] resp [15];
  logic [7:0] cap [16];
  logic [7:0] tx_m [15];
  logic [7:0] rx_m [15];
  logic [7:0] mb;

  spi_frame_master dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .cmd(cmd), .tx_len(tx_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .len_err(len_err), .frame_err(frame_err), .status(status),
    .spi_ncs(spi_ncs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 sysclk = ~sysclk;

  // slave: presents resp MSB first, changes miso after each sck fall, captures mosi on sck rise
  always @(negedge sysclk) begin
    if (!spi_ncs && p_ncs) begin
      ncs_falls++;
      if (gap_run < min_gap) min_gap = gap_run;
      bit_o = 0;
      bit_i = 0;
      mb = resp[0];
      spi_miso = mb[7];
    end else if (!spi_ncs && !spi_sck && p_sck) begin
      bit_o++;
      mb = bit_o < 120 ? resp[bit_o / 8] : 8'h00;
      spi_miso = mb[7 - bit_o % 8];
    end
    if (!spi_ncs && spi_sck && !p_sck) begin
      if (bit_i < 128) cap[bit_i / 8] = {cap[bit_i / 8][6:0], spi_mosi};
      bit_i++;
      sck_rises++;
    end
    gap_run = spi_ncs ? gap_run + 1 : 0;
    if (!spi_ncs) ncs_low++;
    if (done) done_cnt++;
    p_ncs = spi_ncs;
    p_sck = spi_sck;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_payload();
    for (int i = 1; i < 15; i++) begin
      wr_addr = 4'(i);
      wr_data = 8'($urandom);
      wr_en = 1;
      @(negedge sysclk);
      tx_m[i] = wr_data;
    end
    wr_en = 0;
  endtask

  task automatic fill_resp(input bit good_marker);
    for (int i = 0; i < 15; i++) resp[i] = 8'($urandom);
    if (good_marker) resp[0][7:6] = 2'b10;
  endtask

  task automatic check_rx(input string tag);
    for (int i = 0; i < 15; i++) begin
      rd_addr = 4'(i);
      @(negedge sysclk);
      chk($sformatf("%s_rx%0d", tag, i), rd_data, rx_m[i]);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] c, input int len);
    int n, lo0, dn0, fl0, sr0, t;
    n = len + 1;
    lo0 = ncs_low; dn0 = done_cnt; fl0 = ncs_falls; sr0 = sck_rises;
    cmd = c; tx_len = 4'(len); start = 1;
    @(negedge sysclk);
    start = 0;
    chk({tag, "_ncs_fall"}, spi_ncs, 0);
    chk({tag, "_mosi_first"}, spi_mosi, c[7]);
    repeat (5) @(negedge sysclk);
    chk({tag, "_sck_before_rise"}, spi_sck, 0);
    @(negedge sysclk);
    chk({tag, "_sck_first_rise"}, spi_sck, 1);
    repeat (40) @(negedge sysclk);
    start = 1; tx_len = 4'($urandom); cmd = 8'($urandom);
    wr_en = 1; wr_addr = 4'($urandom_range(1, 14)); wr_data = 8'($urandom);
    @(negedge sysclk);
    start = 0; wr_en = 0;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge sysclk);
      t++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_ncs_rise"}, spi_ncs, 1);
    chk({tag, "_status"}, status, resp[0]);
    chk({tag, "_frame_err"}, frame_err, resp[0][7:6] != 2'b10);
    repeat (3) @(negedge sysclk);
    chk({tag, "_busy_in_gap"}, busy, 1);
    chk({tag, "_done_pulse"}, done, 0);
    @(negedge sysclk);
    chk({tag, "_busy_end"}, busy, 0);
    repeat (20) @(negedge sysclk);
    chk({tag, "_ncs_low_cycles"}, ncs_low - lo0, 4 + 64 * n);
    chk({tag, "_sck_rises"}, sck_rises - sr0, 8 * n);
    chk({tag, "_done_count"}, done_cnt - dn0, 1);
    chk({tag, "_ncs_falls"}, ncs_falls - fl0, 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_mosi_byte%0d", tag, i), cap[i], i == 0 ? c : tx_m[i]);
      rx_m[i] = resp[i];
    end
    check_rx(tag);
  endtask

  initial begin
    int t, fl0, dn0, sr0;
    for (int i = 0; i < 15; i++) rx_m[i] = 8'h00;
    repeat (3) @(negedge sysclk);
    chk("rst_ncs", spi_ncs, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_status", status, 0);
    check_rx("rst");
    rst_n = 1;
    @(negedge sysclk);
    fill_payload();

    fill_resp(1);
    resp[0] = 8'hA0; resp[1] = 8'h12; resp[2] = 8'h34;
    run_frame("enc_read", {spi_cmd_pkg::CMD_READ, spi_cmd_pkg::ENCODER_COUNT}, 10);

    fill_resp(1);
    run_frame("motor_en", {spi_cmd_pkg::CMD_WRITE, spi_cmd_pkg::TOGGLE_MOTOR_EN}, 0);

    fill_resp(0);
    resp[0] = 8'h5F;
    run_frame("bad_marker", 8'($urandom), int'($urandom_range(0, 14)));

    fl0 = ncs_falls;
    cmd = 8'($urandom); tx_len = 4'd15; start = 1;
    @(negedge sysclk);
    start = 0;
    chk("len_err_pulse", len_err, 1);
    chk("len_err_ncs", spi_ncs, 1);
    chk("len_err_busy", busy, 0);
    @(negedge sysclk);
    chk("len_err_clear", len_err, 0);
    repeat (20) @(negedge sysclk);
    chk("len_err_no_frame", ncs_falls - fl0, 0);
    chk("len_err_busy_after", busy, 0);

    for (int f = 0; f < 6; f++) begin
      fill_payload();
      fill_resp($urandom_range(0, 1) == 1);
      run_frame($sformatf("rand%0d", f), 8'($urandom), int'($urandom_range(0, 14)));
    end

    fill_resp(1);
    dn0 = done_cnt; sr0 = sck_rises;
    cmd = 8'h91; tx_len = 4'd10; start = 1;
    @(negedge sysclk);
    start = 0;
    t = 0;
    while (sck_rises - sr0 < 37 && t < 2000) begin
      @(negedge sysclk);
      t++;
    end
    chk("rst_mid_reached", sck_rises - sr0 >= 37, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_ncs", spi_ncs, 1);
    chk("rst_mid_sck", spi_sck, 0);
    chk("rst_mid_mosi", spi_mosi, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge sysclk);
    rst_n = 1;
    repeat (800) @(negedge sysclk);
    chk("rst_mid_no_done", done_cnt - dn0, 0);
    chk("rst_mid_idle_ncs", spi_ncs, 1);
    for (int i = 0; i < 15; i++) rx_m[i] = 8'h00;
    check_rx("rst_mid");
    fill_payload();
    fill_resp(1);
    run_frame("after_rst", 8'h91, 10);

    fill_resp(1);
    fl0 = ncs_falls; dn0 = done_cnt;
    cmd = 8'h30; tx_len = 4'd0; start = 1;
    repeat (700) @(negedge sysclk);
    start = 0;
    t = 0;
    while (busy && t < 500) begin
      @(negedge sysclk);
      t++;
    end
    chk("b2b_idle", busy, 0);
    repeat (5) @(negedge sysclk);
    chk("b2b_frames", ncs_falls - fl0 >= 5, 1);
    chk("b2b_done_per_frame", done_cnt - dn0, ncs_falls - fl0);
    chk("b2b_min_gap", min_gap >= 5, 1);
    rx_m[0] = resp[0];
    check_rx("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
